// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch sequencer for the matrix engine.
// Issues reads to the 16x32 instruction store (1-cycle read latency),
// captures returned words into a 2-entry FIFO and presents them to the
// decoder over a valid/ready handshake. A credit check (buffer occupancy
// plus the read in flight) keeps the FIFO from overflowing while the
// decoder stalls.
// Build option: define INST_FETCH_LOOP_EN to wrap pc back to 0 after the
// last address and keep fetching until abort (no DRAIN, no done pulse).
module inst_fetch #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] prog_len,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              inst_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;   // address of the read in flight
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] fifo_data_q [0:1];
  logic [1:0]        fifo_last_q;

  logic              xfer_s;
  logic              credit_ok_s;
  logic              issue_s;
  logic              last_issue_s;
  logic              wr_s;
  logic              wr_last_s;
  logic              head_last_s;

  // Handshake, credit and issue decisions from registered state.
  always_comb begin
    xfer_s       = (occ_q != 2'd0) & inst_ready;
    credit_ok_s  = (occ_q + {1'b0, inflight_q}) < 2'd2;
    issue_s      = (state_q == S_FETCH) & (credit_ok_s | xfer_s);
    last_issue_s = issue_s & (pc_q == len_q);
    wr_s         = inflight_q;
    wr_last_s    = (rd_addr_q == len_q);
    head_last_s  = fifo_last_q[rd_ptr_q];
  end

  // Next-state logic for the FSM, pc, credits and FIFO pointers.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    len_d      = len_q;
    rd_addr_d  = rd_addr_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    done_d     = 1'b0;
    if (abort) begin
      // Flush: the returning word (if any) is dropped with the buffer.
      state_d    = S_IDLE;
      occ_d      = 2'd0;
      inflight_d = 1'b0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
    end else begin
      occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, xfer_s};
      inflight_d = issue_s;
      if (issue_s) begin
        rd_addr_d = pc_q;
      end else begin
        rd_addr_d = rd_addr_q;
      end
      if (wr_s) begin
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (xfer_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            pc_d    = ADDR_ZERO;
            len_d   = prog_len;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          if (last_issue_s) begin
`ifdef INST_FETCH_LOOP_EN
            pc_d    = ADDR_ZERO;
            state_d = S_FETCH;
`else
            // pc parks on the last address so it never wraps.
            pc_d    = pc_q;
            state_d = S_DRAIN;
`endif
          end else if (issue_s) begin
            pc_d = pc_q + ADDR_ONE;
          end else begin
            pc_d = pc_q;
          end
        end
        S_DRAIN: begin
          if (xfer_s && head_last_s) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= ADDR_ZERO;
      len_q      <= ADDR_ZERO;
      rd_addr_q  <= ADDR_ZERO;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      len_q      <= len_d;
      rd_addr_q  <= rd_addr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      done_q     <= done_d;
    end
  end

  // FIFO storage: capture the word returned for the read in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fifo_data_q[0] <= {DATA_W{1'b0}};
      fifo_data_q[1] <= {DATA_W{1'b0}};
      fifo_last_q    <= 2'b00;
    end else if (wr_s && !abort) begin
      fifo_data_q[wr_ptr_q] <= mem_data;
      fifo_last_q[wr_ptr_q] <= wr_last_s;
    end
  end

  assign mem_en     = issue_s;
  assign mem_addr   = pc_q;
  assign inst_data  = fifo_data_q[rd_ptr_q];
  assign inst_last  = head_last_s;
  assign inst_valid = (occ_q != 2'd0);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch sequencer for the matrix engine, sitting directly upstream of `inst_register`. It generates the address and enable sequence for the 16×32 instruction store. It captures each returned word into a 2-entry buffer and presents instructions to the decoder over a valid/ready handshake. The buffer lets the decoder stall without losing reads already in flight.

## Interface
Parameters:
- `ADDR_W`, 4: instruction address width; must match `inst_register`.
- `DATA_W`, 32: instruction width.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a program run from address 0; sampled only in IDLE.
- `abort`  in  1  terminate the run, flush the buffer and return to IDLE.
- `prog_len`  in  ADDR_W  address of the last instruction; sampled when `start` is accepted.
- `mem_en`  out  1  read enable to `inst_register`.
- `mem_addr`  out  ADDR_W  read address to `inst_register`.
- `mem_data`  in  DATA_W  read data from `inst_register`.
- `inst_data`  out  DATA_W  instruction to the decoder.
- `inst_valid`  out  1  `inst_data` is valid.
- `inst_ready`  in  1  decoder accepts the instruction; a transfer occurs when `inst_valid & inst_ready` at a rising edge.
- `inst_last`  out  1  qualifies `inst_data` as the word from `prog_len`.
- `busy`  out  1  high in FETCH and DRAIN.
- `done`  out  1  one-cycle pulse after the last instruction transfers.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE→FETCH when `start`=1; `pc` is cleared to 0 and `prog_len` is latched.
  - FETCH→DRAIN on the edge that issues the read of the latched `prog_len`.
  - DRAIN→IDLE on the edge where the `inst_last` word transfers; `done` pulses in the following cycle.
  - Any state→IDLE on `abort`=1.
- Memory contract: `inst_register` samples `mem_addr` on the rising edge where `mem_en`=1. `mem_data` holds that word for the whole following cycle (1-cycle read latency).
- Credit rule:
  - `occ` (0..2) counts buffer entries; `inflight` (0/1) marks a read issued on the previous edge.
  - `mem_en` = FETCH & (`occ` + `inflight` < 2, or a transfer occurs this cycle).
  - `mem_en` is combinational from registered state and `inst_ready`.
- The buffer is a 2-entry FIFO. A word is written when `inflight`=1, and the entry is tagged last if its address equals latched `prog_len`.
- `inst_data` and `inst_last` show the FIFO head. `inst_valid` = (`occ` > 0).
- `pc` increments by 1 per issued read. There is no wrap in the base build.
- `start` while `busy`=1 is ignored.
- `abort` has priority over `start` in the same cycle.
- On abort:
  - `occ` and `inflight` are cleared and the returning word is discarded.
  - `inst_valid` is 0 from the next cycle.
  - No `done` pulse is produced.
- `prog_len`=0 fetches exactly one instruction, with `inst_last`=1.
- `prog_len`=15 issues address 15 and never wraps `pc`.

## Timing
- Reset values: `mem_en`=0, `mem_addr`=0, `inst_data`=0, `inst_valid`=0, `inst_last`=0, `busy`=0, `done`=0.
- Start to first issue: `start` high at edge k → `mem_en`=1 and `mem_addr`=0 during cycle k+1.
- First instruction: captured at edge k+2; `inst_valid`=1 from cycle k+2 onward.
- Steady state with `inst_ready`=1: one instruction per cycle, with no bubbles.
- With `inst_ready`=0: at most 2 words are buffered and `mem_en` stays 0. Issue resumes in the same cycle that `inst_ready` returns high.
- Reset assertion mid-run forces all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- `INST_FETCH_LOOP_EN`:
  - Defined: after issuing `prog_len`, `pc` wraps to 0 and FETCH continues. DRAIN is never entered, `done` never pulses, and a run ends only via `abort`. `inst_last` still marks each `prog_len` word.
  - Undefined: the run stops after `prog_len`, as described above.

## Test plan
- Reset, then `start` with `prog_len`=3 and `inst_ready`=1 → `mem_addr` sequence 0,1,2,3 on consecutive cycles. Words 0–3 appear with `inst_valid` from start+2, `inst_last` on word 3, `done` one cycle after its transfer, and `busy` low afterwards.
- `prog_len`=15 with `inst_ready` toggling 1,0,0,1 → no word lost or duplicated, `mem_en`=0 while `occ`+`inflight`=2, and all 16 words delivered in order.
- `prog_len`=0 → exactly one transfer, with `inst_last`=1 and `done` pulsed.
- `abort` asserted 2 cycles after `start` while the decoder is stalled → `inst_valid`=0 next cycle, no `done`, and a subsequent `start` refetches from address 0.
- `start` pulsed again while busy → ignored; the address sequence is unaffected.
- `INST_FETCH_LOOP_EN` defined with `prog_len`=2 → addresses 0,1,2,0,1,2,… and `inst_last` on every third word, until `abort`.
